// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared defaults, mode codes and flag helpers
// for the pipelined adder and its slices.
package pipe_adder_pkg;

    localparam int ADD_WIDTH_DEF  = 32;
    localparam int ADD_STAGES_DEF = 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed overflow: like-signed operands yielding a sign flip.
    function automatic logic ovf_of(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// pipe_adder_slice: adds slice IDX of A and effective B with the carry
// from the previous stage, then registers the whole bundle onward.
module pipe_adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEF,
    parameter int SW    = ADD_WIDTH_DEF / ADD_STAGES_DEF,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             c_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o
);

    localparam int LO = IDX * SW;

    logic [SW:0]      part;
    logic [WIDTH-1:0] sum_d;
    logic             valid_q;
    logic             c_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;

    assign part = {1'b0, a_i[LO +: SW]}
                + {1'b0, b_i[LO +: SW]}
                + {{SW{1'b0}}, c_i};

    // Slices at and above IDX are still zero in sum_i, so OR merges.
    always_comb begin
        sum_d = sum_i | (WIDTH'(part[SW-1:0]) << LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
        end else if (load_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                a_q   <= a_i;
                b_q   <= b_i;
                sum_q <= sum_d;
                c_q   <= part[SW];
            end
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;
    assign c_o     = c_q;

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep carry-pipelined add/sub with valid/ready
// on both sides and per-stage bubble collapse.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = ADD_WIDTH_DEF,
    parameter int STAGES = ADD_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SW = WIDTH / STAGES;

    logic [STAGES-1:0]           vld;
    logic [STAGES:0]             rdy;
    logic [STAGES:0][WIDTH-1:0]  a_s;
    logic [STAGES:0][WIDTH-1:0]  b_s;
    logic [STAGES:0][WIDTH-1:0]  sum_s;
    logic [STAGES:0]             c_s;
    logic [2*WIDTH-1:0]          tail_unused;

    assign a_s[0]   = in_a;
    assign b_s[0]   = (in_sub == OP_SUB) ? ~in_b : in_b;
    assign sum_s[0] = '0;
    assign c_s[0]   = in_sub;

    // A stage may load when empty or when its successor takes its data.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld[k] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic pv;
        if (k == 0) begin : g_first
            assign pv = in_valid;
        end else begin : g_next
            assign pv = vld[k-1];
        end

        pipe_adder_slice #(
            .WIDTH (WIDTH),
            .SW    (SW),
            .IDX   (k)
        ) u_slice (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (rdy[k]),
            .valid_i (pv),
            .a_i     (a_s[k]),
            .b_i     (b_s[k]),
            .sum_i   (sum_s[k]),
            .c_i     (c_s[k]),
            .valid_o (vld[k]),
            .a_o     (a_s[k+1]),
            .b_o     (b_s[k+1]),
            .sum_o   (sum_s[k+1]),
            .c_o     (c_s[k+1])
        );
    end

    assign tail_unused = {a_s[STAGES], b_s[STAGES]};

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES-1];
    assign out_sum   = sum_s[STAGES];
    assign out_carry = c_s[STAGES];
    assign out_ovf   = ovf_of(a_s[STAGES][WIDTH-1],
                              b_s[STAGES][WIDTH-1],
                              sum_s[STAGES][WIDTH-1]);
    assign out_zero  = (out_sum == '0);

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (32/2) plus
// 8/4, 48/3 and 64/1 instances checked against a reference model.
module tb_pipe_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        v;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [31:0] out_sum;
    logic        out_carry, out_ovf, out_zero;

    logic        x_valid, x_sub;
    logic [63:0] x_a, x_b;
    logic        i8_r, o8_v, o8_c, o8_o, o8_z;
    logic [7:0]  o8_s;
    logic        i48_r, o48_v, o48_c, o48_o, o48_z;
    logic [47:0] o48_s;
    logic        i64_r, o64_v, o64_c, o64_o, o64_z;
    logic [63:0] o64_s;

    res_t q[$];
    res_t mon_e;
    res_t xr;
    vec_t tv[9];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   stalls    = 0;

    pipe_adder #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry),
        .out_ovf(out_ovf), .out_zero(out_zero)
    );

    pipe_adder #(.WIDTH(8), .STAGES(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(x_valid), .in_ready(i8_r),
        .in_a(x_a[7:0]), .in_b(x_b[7:0]), .in_sub(x_sub),
        .out_valid(o8_v), .out_ready(1'b1),
        .out_sum(o8_s), .out_carry(o8_c),
        .out_ovf(o8_o), .out_zero(o8_z)
    );

    pipe_adder #(.WIDTH(48), .STAGES(3)) dut48 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(x_valid), .in_ready(i48_r),
        .in_a(x_a[47:0]), .in_b(x_b[47:0]), .in_sub(x_sub),
        .out_valid(o48_v), .out_ready(1'b1),
        .out_sum(o48_s), .out_carry(o48_c),
        .out_ovf(o48_o), .out_zero(o48_z)
    );

    pipe_adder #(.WIDTH(64), .STAGES(1)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(x_valid), .in_ready(i64_r),
        .in_a(x_a), .in_b(x_b), .in_sub(x_sub),
        .out_valid(o64_v), .out_ready(1'b1),
        .out_sum(o64_s), .out_carry(o64_c),
        .out_ovf(o64_o), .out_zero(o64_z)
    );

    function automatic res_t model(
        input int w, input logic [63:0] a, input logic [63:0] b,
        input logic sub
    );
        logic [64:0] t;
        logic [63:0] m, am, bm;
        res_t r;
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am = a & m;
        bm = (sub ? ~b : b) & m;
        t  = {1'b0, am} + {1'b0, bm} + {64'd0, sub};
        r.sum = t[63:0] & m;
        r.c   = t[w];
        r.z   = (r.sum == 64'd0);
        r.v   = (am[w-1] == bm[w-1]) && (r.sum[w-1] != am[w-1]);
        return r;
    endfunction

    function automatic res_t mk(
        input logic [31:0] s, input logic c, input logic v
    );
        res_t r;
        r.sum = {32'd0, s};
        r.c   = c;
        r.v   = v;
        r.z   = (s == 32'd0);
        return r;
    endfunction

    task automatic chk(
        input string nm, input logic [63:0] act, input logic [63:0] exp
    );
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic send(
        input logic [31:0] a, input logic [31:0] b, input logic sub,
        input res_t exp
    );
        bit acc = 1'b0;
        int n   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                stalls++;
                n++;
                if (n > 100) begin
                    chk("send_timeout", 0, 1);
                    break;
                end
            end
        end
        if (acc) q.push_back(exp);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain(input string nm);
        for (int c = 0; c < 50 && q.size() != 0; c++) @(posedge clk);
        chk(nm, 64'(q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {32'd0, out_sum}, 64'hDEAD);
            end else begin
                mon_e = q.pop_front();
                chk("sum", {32'd0, out_sum}, mon_e.sum);
                chk("carry", {63'd0, out_carry}, {63'd0, mon_e.c});
                chk("ovf", {63'd0, out_ovf}, {63'd0, mon_e.v});
                chk("zero", {63'd0, out_zero}, {63'd0, mon_e.z});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] xa[6];
        logic [63:0] xb[6];
        logic        xs[6];
        int          l8, l48, l64, seen;

        tv[0] = '{32'h00000004, 32'h00400000, 1'b0, 32'h00400004, 1'b0, 1'b0};
        tv[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tv[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tv[3] = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tv[4] = '{32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tv[5] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
        tv[6] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tv[7] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        tv[8] = '{32'hFFFF0000, 32'h00010000, 1'b0, 32'h00000000, 1'b1, 1'b0};

        xa = '{64'hFFFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 64'h55,
               64'h10, 64'h8000000000000080, 64'h5555555555555555};
        xb = '{64'h1, 64'h1, 64'h2B, 64'h1, 64'h1, 64'hAAAAAAAAAAAAAAAB};
        xs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        out_ready = 1'b1;
        x_valid = 1'b0; x_a = '0; x_b = '0; x_sub = 1'b0;

        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 0);
        chk("rst_in_ready", {63'd0, in_ready}, 1);
        chk("rst_sum", {32'd0, out_sum}, 0);
        chk("rst_flags", {61'd0, out_carry, out_ovf, out_zero}, 64'b001);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", {63'd0, in_ready}, 1);

        // First result must appear exactly two cycles after acceptance.
        send(tv[0].a, tv[0].b, tv[0].sub, mk(tv[0].s, tv[0].c, tv[0].v));
        @(negedge clk);
        chk("lat_cycle1", {63'd0, out_valid}, 0);
        @(negedge clk);
        chk("lat_cycle2", {63'd0, out_valid}, 1);
        wait_drain("drain_lat");

        stalls = 0;
        for (int i = 1; i < 9; i++) begin
            send(tv[i].a, tv[i].b, tv[i].sub,
                 mk(tv[i].s, tv[i].c, tv[i].v));
        end
        chk("throughput_stalls", 64'(stalls), 0);
        wait_drain("drain_directed");

        // Burst of 8 into a stalled consumer.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [31:0] a, b;
                    a = 32'h89ABCDEF ^ (32'h11111111 * i);
                    b = 32'h7654FFFF + 32'h01000001 * i;
                    send(a, b, 1'(i), model(32, {32'd0, a}, {32'd0, b}, 1'(i)));
                end
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("full_in_ready", {63'd0, in_ready}, 0);
                chk("full_out_valid", {63'd0, out_valid}, 1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("drain_burst");

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send(32'h11, 32'h22, 1'b0, mk(32'h33, 1'b0, 1'b0));
        send(32'h44, 32'h55, 1'b0, mk(32'h99, 1'b0, 1'b0));
        chk("inflight_valid", {63'd0, out_valid}, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 0);
        chk("arst_sum", {32'd0, out_sum}, 0);
        q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_stale", 64'(seen), 0);
        @(posedge clk); #1;
        send(32'h4, 32'h4, 1'b0, mk(32'h8, 1'b0, 1'b0));
        wait_drain("drain_post_rst");

        // Other widths and depths against the reference model.
        for (int i = 0; i < 18; i++) begin
            if (i < 6) begin
                x_a = xa[i]; x_b = xb[i]; x_sub = xs[i];
            end else begin
                x_a = {$urandom, $urandom};
                x_b = {$urandom, $urandom};
                x_sub = 1'($urandom_range(0, 1));
            end
            x_valid = 1'b1;
            @(negedge clk);
            chk("x_in_ready", {61'd0, i8_r, i48_r, i64_r}, 64'b111);
            @(posedge clk); #1 x_valid = 1'b0;
            l8 = 0; l48 = 0; l64 = 0;
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                if (o8_v && l8 == 0) begin
                    l8 = c;
                    xr = model(8, x_a, x_b, x_sub);
                    chk("w8_sum", {56'd0, o8_s}, xr.sum);
                    chk("w8_flags", {61'd0, o8_c, o8_o, o8_z},
                        {61'd0, xr.c, xr.v, xr.z});
                end
                if (o48_v && l48 == 0) begin
                    l48 = c;
                    xr = model(48, x_a, x_b, x_sub);
                    chk("w48_sum", {16'd0, o48_s}, xr.sum);
                    chk("w48_flags", {61'd0, o48_c, o48_o, o48_z},
                        {61'd0, xr.c, xr.v, xr.z});
                end
                if (o64_v && l64 == 0) begin
                    l64 = c;
                    xr = model(64, x_a, x_b, x_sub);
                    chk("w64_sum", o64_s, xr.sum);
                    chk("w64_flags", {61'd0, o64_c, o64_o, o64_z},
                        {61'd0, xr.c, xr.v, xr.z});
                end
            end
            chk("w8_lat", 64'(l8), 4);
            chk("w48_lat", 64'(l48), 3);
            chk("w64_lat", 64'(l64), 1);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL: parameter WIDTH, default 32, operand/result width; legal values 8..64.
REQ-002 SHALL: parameter STAGES, default 2, pipeline depth; 1..4; WIDTH divisible by STAGES.
REQ-003 SHALL: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL: in_valid  input  1  operands presented this cycle.
REQ-006 SHALL: in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL: in_a  input  WIDTH  operand A.
REQ-008 SHALL: in_b  input  WIDTH  operand B.
REQ-009 SHALL: in_sub  input  1  0 = A+B, 1 = A-B (A + ~B + 1).
REQ-010 SHALL: out_valid  output  1  result present.
REQ-011 SHALL: out_ready  input  1  consumer accepts result.
REQ-012 SHALL: out_sum  output  WIDTH  result modulo 2^WIDTH.
REQ-013 SHALL: out_carry  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 SHALL: out_ovf  output  1  signed two's-complement overflow.
REQ-015 SHALL: out_zero  output  1  out_sum == 0.

Function
REQ-016 SHALL: transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-017 SHALL: split operands into STAGES slices of WIDTH/STAGES bits; stage k adds slice k plus registered carry from stage k-1; upper unprocessed slices ride along registered.
REQ-018 SHALL: latency exactly STAGES cycles from accepted input to out_valid with no backpressure.
REQ-019 SHALL: sustain one transaction per cycle when out_ready held high.
REQ-020 SHALL: each stage hold a valid bit; stage advances when its successor is empty or advancing; in_ready = stage-0 empty or advancing (per-stage bubble collapse, no global stall).
REQ-021 SHALL: when out_valid && !out_ready, out_sum/flags held stable until accepted.
REQ-022 SHALL: in_sub latched with operands; stage 0 carry-in = in_sub; B slices inverted when in_sub.
REQ-023 SHALL: out_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), B' = effective (possibly inverted) B.
REQ-024 SHALL: out_zero computed combinationally from registered out_sum.
REQ-025 SHALL: simultaneous input accept and output accept on a full pipeline both succeed in same cycle.
REQ-026 SHALL: in_valid without in_ready leave pipeline state unchanged; operands need not be held stable by producer beyond the accepting cycle.
REQ-027 SHALL: STAGES=1 behave as registered adder with latency 1.

Reset
REQ-028 SHALL: rst_n low clear all stage valid bits immediately (asynchronous), out_valid = 0.
REQ-029 SHALL: out_sum, out_carry, out_ovf reset to 0; out_zero thus 1 during reset.
REQ-030 SHALL: in_ready = 1 while rst_n high after reset; in-flight transactions discarded on mid-operation reset.

Structure
REQ-031 SHALL: shared package pipe_adder_pkg holds defaults ADD_WIDTH_DEF=32, ADD_STAGES_DEF=2 and mode constants OP_ADD=0, OP_SUB=1.
REQ-032 SHALL: one sub-module pipe_adder_slice (slice add with carry-in/out, registered, valid/advance) instantiated STAGES times via generate.
REQ-033 SHALL: existing PC+4 and 32-bit add functions remain expressible as WIDTH=32, in_sub=0.

Verification
REQ-034 SHALL: WIDTH=32, STAGES=2, A=0x00000004, B=0x00400000, add -> out_sum=0x00400004 two cycles later, carry=0, ovf=0.
REQ-035 SHALL: A=0x7FFFFFFF, B=0x00000001, add -> sum=0x80000000, ovf=1, carry=0; A=0xFFFFFFFF+B=1 -> sum=0, carry=1, zero=1.
REQ-036 SHALL: sub A=5, B=5 -> sum=0, zero=1, carry=1; sub A=3, B=5 -> sum=0xFFFFFFFE, carry=0.
REQ-037 SHALL: 8 back-to-back inputs, out_ready held 0 for 3 cycles then 1 -> in_ready drops when full, all 8 results in order, none lost or duplicated.
REQ-038 SHALL: rst_n asserted with 2 transactions in flight -> out_valid falls same cycle, no stale result after release.
REQ-039 SHALL: random operands/modes over STAGES 1..4, WIDTH 8/32/64 -> results match reference model, slice carry across every boundary exercised.
